max_exp_sched: RTL
==================

# max_exp_sched

Sequential controller that determines the maximum exponent over a 3x3 window of FP16 product exponents, honouring a per-term skip mask, using a single shared compare/select step instead of a nine-input comparator tree. It accepts one window per valid/ready handshake, scans the nine terms one per cycle, then presents the maximum exponent, the winning term index, and per-term alignment shift amounts to the MAC adder stage. It sits between the multiplier array and the alignment shifters of the MAC subsystem.

## Interface
- EXP_W, 6, exponent field width (FP16 exponent plus one guard bit)
- N_TERMS, 9, number of terms per window; only 9 is supported
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  window present on i_skip/i_exp*
- o_ready  output  1  block can accept a window (high only in IDLE)
- i_skip  input  9  skip mask; bit 8 = term 1 ... bit 0 = term 9
- i_exp1..i_exp9  input  EXP_W each  term exponents
- o_valid  output  1  result valid, held until accepted
- i_ready  input  1  downstream accepts result
- o_max_exp  output  EXP_W  maximum unskipped exponent (0 if all skipped)
- o_max_idx  output  4  1-based index of first term reaching max; 4'd15 if all skipped
- o_shift  output  9*EXP_W  packed shift amounts, term 1 in MSBs
- o_all_skip  output  1  all nine skip bits set

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, capture i_skip and all nine exponents into window registers; clear max to 0, idx to 15, scan counter to 0; go SCAN. i_exp*/i_skip ignored outside this capture.
- SCAN: each cycle examine term counter+1. Skipped terms act as exponent 0 and never update idx. Unskipped term with exp strictly greater than current max, or first unskipped term when idx==15, updates max and idx (ties keep earlier index). Counter 0..8; after term 9 go DONE.
- DONE: o_valid=1; outputs stable. o_shift[i] = max - exp_i for unskipped terms (always >= 0, fits EXP_W); skipped terms = all ones (6'h3F), meaning fully shifted out. o_all_skip = &skip_reg. On i_ready go IDLE.
- No bypass: a new window cannot be accepted in the DONE->IDLE cycle.

## Timing
- Reset (async, immediate): state IDLE, o_ready=1, o_valid=0, o_max_exp=0, o_max_idx=15, o_shift=0, o_all_skip=0, window registers 0.
- Accept on edge E0; terms 1..9 processed on edges E1..E9; o_valid high after E9. Latency 9 cycles accept-to-valid.
- Result accepted on edge Ea where o_valid&&i_ready; o_valid low and o_ready high after Ea; earliest next accept Ea+1. Minimum throughput one window per 11 cycles.
- i_ready high on the first DONE cycle: valid for exactly one cycle.
- i_ready low: outputs hold indefinitely, no change.
- Reset mid-SCAN or mid-DONE: window discarded, no partial result emitted.
- o_max_exp/o_max_idx are registered; o_shift/o_all_skip are combinational from registers, valid only while o_valid.

## Structure
- Package max_exp_pkg: EXP_W, N_TERMS, IDX_NONE (4'd15), SHIFT_SKIP (all ones), state enum {IDLE, SCAN, DONE}.
- One sub-module max_exp_step: combinational compare/select of (cur_max, cur_idx, exp, skip, term_idx) -> (next_max, next_idx); instantiated once, shared across scan cycles.
- FSM, counter, window registers, shift generation in top.

## Test plan
- Exps 3,7,2,9,1,9,4,0,5, skip 0 -> after 9 cycles o_max_exp=9, o_max_idx=4, o_shift = 6,2,7,0,8,0,5,9,4.
- Same exps, skip 9'b000100000 (term 4 skipped) -> max 9, idx 6, shift[4]=6'h3F.
- Skip 9'h1FF, any exps -> max 0, idx 15, o_all_skip=1, all shifts 6'h3F.
- All exps 5, skip 0 -> max 5, idx 1, all shifts 0; hold i_ready low 20 cycles -> outputs stable, o_ready=0 throughout.
- Back-to-back: i_valid held high, i_ready high -> accepts spaced exactly 11 cycles, each o_valid one cycle wide.
- Assert i_rst during SCAN cycle 4 -> immediately o_valid=0, o_ready=1, idx 15; no result appears; next window processes correctly.

Source files
------------

// File: rtl/max_exp_sched_pkg.sv
// Shared types and constants for the max-exponent scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package max_exp_pkg;
   localparam int EXP_W   = 6;
   localparam int N_TERMS = 9;

   localparam logic [3:0]       IDX_NONE   = 4'd15;
   localparam logic [EXP_W-1:0] SHIFT_SKIP = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/max_exp_sched_if.sv
// Window-in / result-out bundle between multiplier array, scheduler and aligner.
// Latency: n/a (wiring only).
// Backpressure: i_valid/o_ready on the window side, o_valid/i_ready on the result side.
interface max_exp_sched_if;
   import max_exp_pkg::*;

   logic                     i_valid;
   logic                     o_ready;
   logic [N_TERMS-1:0]       i_skip;
   logic [EXP_W-1:0]         i_exp1;
   logic [EXP_W-1:0]         i_exp2;
   logic [EXP_W-1:0]         i_exp3;
   logic [EXP_W-1:0]         i_exp4;
   logic [EXP_W-1:0]         i_exp5;
   logic [EXP_W-1:0]         i_exp6;
   logic [EXP_W-1:0]         i_exp7;
   logic [EXP_W-1:0]         i_exp8;
   logic [EXP_W-1:0]         i_exp9;
   logic                     o_valid;
   logic                     i_ready;
   logic [EXP_W-1:0]         o_max_exp;
   logic [3:0]               o_max_idx;
   logic [N_TERMS*EXP_W-1:0] o_shift;
   logic                     o_all_skip;

   // Upstream/downstream side: supplies windows and consumes results.
   modport master (
      output i_valid, i_skip, i_exp1, i_exp2, i_exp3, i_exp4, i_exp5,
             i_exp6, i_exp7, i_exp8, i_exp9, i_ready,
      input  o_ready, o_valid, o_max_exp, o_max_idx, o_shift, o_all_skip
   );

   // Scheduler side.
   modport slave (
      input  i_valid, i_skip, i_exp1, i_exp2, i_exp3, i_exp4, i_exp5,
             i_exp6, i_exp7, i_exp8, i_exp9, i_ready,
      output o_ready, o_valid, o_max_exp, o_max_idx, o_shift, o_all_skip
   );
endinterface

// File: rtl/max_exp_sched_step.sv
// One compare/select step of the running-maximum scan over a window.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module max_exp_step
   import max_exp_pkg::*;
(
   input  logic [EXP_W-1:0] cur_max,
   input  logic [3:0]       cur_idx,
   input  logic [EXP_W-1:0] term_exp,
   input  logic             skip,
   input  logic [3:0]       term_idx,
   output logic [EXP_W-1:0] next_max,
   output logic [3:0]       next_idx
);

   // Strictly-greater keeps the earliest index on ties; the first unskipped
   // term always wins so an all-zero window still reports a real index.
   always_comb begin
      next_max = cur_max;
      next_idx = cur_idx;
      if (!skip && ((cur_idx == IDX_NONE) || (term_exp > cur_max))) begin
         next_max = term_exp;
         next_idx = term_idx;
      end
   end

endmodule

// File: rtl/max_exp_sched.sv
// Finds the max exponent of a 3x3 window by scanning one term per cycle, then emits shifts.
// Latency: 9 cycles accept-to-valid; one window per 11 cycles at best.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready.
module max_exp_sched
   import max_exp_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   max_exp_sched_if.slave  bus
);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [N_TERMS-1:0] skip_reg;
   logic [EXP_W-1:0] exp_reg [N_TERMS];
   logic [EXP_W-1:0] max_reg;
   logic [3:0]       idx_reg;
   logic [EXP_W-1:0] step_max;
   logic [3:0]       step_idx;
   logic             accept;

   assign accept = (state == IDLE) && bus.i_valid;

   // Single shared comparator, fed by the term the counter points at.
   max_exp_step u_step (
      .cur_max  (max_reg),
      .cur_idx  (idx_reg),
      .term_exp (exp_reg[cnt]),
      .skip     (skip_reg[4'd8 - cnt]),
      .term_idx (cnt + 4'd1),
      .next_max (step_max),
      .next_idx (step_idx)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt   = state;
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.o_ready = 1'b1;
            if (bus.i_valid) state_nxt = SCAN;
         end
         SCAN: begin
            if (cnt == 4'(N_TERMS - 1)) state_nxt = DONE;
         end
         DONE: begin
            bus.o_valid = 1'b1;
            if (bus.i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Window capture on accept, running max/idx update while scanning.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt      <= '0;
         skip_reg <= '0;
         max_reg  <= '0;
         idx_reg  <= IDX_NONE;
         for (int k = 0; k < N_TERMS; k++) exp_reg[k] <= '0;
      end else if (accept) begin
         cnt        <= '0;
         skip_reg   <= bus.i_skip;
         max_reg    <= '0;
         idx_reg    <= IDX_NONE;
         exp_reg[0] <= bus.i_exp1;
         exp_reg[1] <= bus.i_exp2;
         exp_reg[2] <= bus.i_exp3;
         exp_reg[3] <= bus.i_exp4;
         exp_reg[4] <= bus.i_exp5;
         exp_reg[5] <= bus.i_exp6;
         exp_reg[6] <= bus.i_exp7;
         exp_reg[7] <= bus.i_exp8;
         exp_reg[8] <= bus.i_exp9;
      end else if (state == SCAN) begin
         max_reg <= step_max;
         idx_reg <= step_idx;
         cnt     <= cnt + 4'd1;
      end
   end

   assign bus.o_max_exp  = max_reg;
   assign bus.o_max_idx  = idx_reg;
   assign bus.o_all_skip = &skip_reg;

   // Alignment shifts: skipped terms are pushed fully out; term 1 lands in the MSBs.
   always_comb begin
      bus.o_shift = '0;
      for (int k = 0; k < N_TERMS; k++) begin
         bus.o_shift[(N_TERMS-1-k)*EXP_W +: EXP_W] =
            skip_reg[N_TERMS-1-k] ? SHIFT_SKIP : (max_reg - exp_reg[k]);
      end
   end

endmodule
